// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic array and its tile controller.
//   word_t       : operand / accumulator word carried on every array edge
//   ctrl_state_t : tile controller state, also exposed for debug
package systolic_array_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        READ  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/skew_buffer.sv
// Triangular delay line feeding one edge of the systolic array.
// Lane i delays din[i] by i advances; lane 0 is a straight wire.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears all stages)
//   adv      : shift every lane by one stage
//   lane_en  : per-lane output enable; a disabled lane drives zero
//   din      : one word per lane, sampled when adv is high
//   dout     : delayed (and enable-gated) word per lane
module skew_buffer
    import systolic_array_pkg::*;
#(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic [N-1:0]    lane_en,
    input  word_t [N-1:0]   din,
    output word_t [N-1:0]   dout
);

    word_t [N-1:0] tap;

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign tap[i] = din[i];
        end else begin : g_delay
            word_t stage [i];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < i; s++) stage[s] <= '0;
                end else if (adv) begin
                    stage[0] <= din[i];
                    for (int s = 1; s < i; s++) stage[s] <= stage[s-1];
                end
            end

            assign tap[i] = stage[i-1];
        end

        // The enable masks beats whose operand index falls outside [0,K),
        // so stale register contents never reach the array.
        assign dout[i] = lane_en[i] ? tap[i] : '0;
    end

endmodule

// File: rtl/systolic_controller.sv
// Tile sequencer for the NxN output-stationary systolic array: accepts a
// tile command, reads A columns / B rows, skews them onto the array edges,
// drains the array, then streams the N result rows out.
// Ports:
//   cmd_valid/cmd_ready/cmd_k   : tile command (K = inner dimension)
//   a_rd_*, b_rd_*              : operand buffer reads, 1-cycle latency
//   sa_start/sa_x_in/sa_w_in    : array control and skewed edge inputs
//   sa_y_index/sa_y_out         : array result row select / row data
//   sa_stall                    : array stall, freezes START/FEED/DRAIN
//   out_valid/out_ready/out_row/out_idx/out_last : result row stream
//   done, err, busy             : status (done/err are 1-cycle pulses)
//   dbg_state                   : current FSM state
// Handshakes (cmd and out): a transfer happens on a rising edge where valid
// and ready are both high; the sender keeps its payload stable while valid
// is high and ready is low.
module systolic_controller
    import systolic_array_pkg::*;
#(
    parameter int N    = 4,
    parameter int KMAX = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [$clog2(KMAX+1)-1:0]   cmd_k,
    output logic                        a_rd_en,
    output logic [$clog2(KMAX)-1:0]     a_rd_addr,
    input  word_t [N-1:0]               a_rd_data,
    output logic                        b_rd_en,
    output logic [$clog2(KMAX)-1:0]     b_rd_addr,
    input  word_t [N-1:0]               b_rd_data,
    output logic                        sa_start,
    output word_t [N-1:0]               sa_x_in,
    output word_t [N-1:0]               sa_w_in,
    output logic [$clog2(N)-1:0]        sa_y_index,
    input  word_t [N-1:0]               sa_y_out,
    input  logic                        sa_stall,
    output logic                        out_valid,
    input  logic                        out_ready,
    output word_t [N-1:0]               out_row,
    output logic [$clog2(N)-1:0]        out_idx,
    output logic                        out_last,
    output logic                        done,
    output logic                        err,
    output logic                        busy,
    output ctrl_state_t                 dbg_state
);

    localparam int KW = $clog2(KMAX + 1);
    localparam int AW = $clog2(KMAX);
    localparam int CW = $clog2(KMAX + N);  // holds beat K+N-2
    localparam int RW = $clog2(N);

    ctrl_state_t    state;
    logic [KW-1:0]  k_q;
    logic [CW-1:0]  beat;
    logic [RW-1:0]  row;

    logic           feed_go;
    logic           rd_go;
    logic [AW-1:0]  rd_addr_c;
    logic [CW-1:0]  beat_inc;
    logic [N-1:0]   lane_en;

    assign beat_inc = beat + 1'b1;
    assign feed_go  = (state == FEED) && !sa_stall;

    // Operand reads run one beat ahead of the data they feed: k=0 in START,
    // k=t+1 during FEED beat t. Nothing is read while the array is stalled.
    always_comb begin
        rd_go     = 1'b0;
        rd_addr_c = '0;
        if (!sa_stall) begin
            if (state == START && k_q != '0) begin
                rd_go = 1'b1;
            end else if (state == FEED && int'(beat) + 1 < int'(k_q)) begin
                rd_go     = 1'b1;
                rd_addr_c = beat_inc[AW-1:0];
            end
        end
    end

    // Lane i at beat t carries operand index t-i; it is live only in [0,K).
    always_comb begin
        lane_en = '0;
        for (int i = 0; i < N; i++) begin
            lane_en[i] = (state == FEED) && (int'(beat) >= i)
                         && (int'(beat) - i < int'(k_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k_q   <= '0;
            beat  <= '0;
            row   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (int'(cmd_k) > KMAX) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            k_q   <= cmd_k;
                            state <= START;
                        end
                    end
                end
                START: begin
                    if (!sa_stall) begin
                        beat  <= '0;
                        state <= FEED;
                    end
                end
                FEED: begin
                    if (!sa_stall) begin
                        if (int'(beat) == int'(k_q) + N - 2) begin
                            beat  <= '0;
                            state <= DRAIN;
                        end else begin
                            beat <= beat_inc;
                        end
                    end
                end
                DRAIN: begin
                    if (!sa_stall) begin
                        if (int'(beat) == N - 1) begin
                            beat  <= '0;
                            row   <= '0;
                            state <= READ;
                        end else begin
                            beat <= beat_inc;
                        end
                    end
                end
                READ: begin
                    if (out_ready) begin
                        if (row == RW'(N - 1)) begin
                            row   <= '0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    skew_buffer #(.N(N)) u_skew_x (
        .clk     (clk),
        .rst     (rst),
        .adv     (feed_go),
        .lane_en (lane_en),
        .din     (a_rd_data),
        .dout    (sa_x_in)
    );

    skew_buffer #(.N(N)) u_skew_w (
        .clk     (clk),
        .rst     (rst),
        .adv     (feed_go),
        .lane_en (lane_en),
        .din     (b_rd_data),
        .dout    (sa_w_in)
    );

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign a_rd_en    = rd_go;
    assign b_rd_en    = rd_go;
    assign a_rd_addr  = rd_addr_c;
    assign b_rd_addr  = rd_addr_c;
    assign sa_start   = (state == START);
    assign sa_y_index = row;
    assign out_valid  = (state == READ);
    assign out_idx    = row;
    assign out_last   = (state == READ) && (row == RW'(N - 1));
    assign out_row    = (state == READ) ? sa_y_out : '0;
    assign dbg_state  = state;

endmodule

// File: tb/tb_systolic_controller.sv
module tb_systolic_controller;
    import systolic_array_pkg::*;

    localparam int N    = 4;
    localparam int KMAX = 64;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int AW   = $clog2(KMAX);
    localparam int RW   = $clog2(N);
    localparam int W    = N * 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               cmd_valid, cmd_ready;
    logic [KW-1:0]      cmd_k;
    logic               a_rd_en, b_rd_en;
    logic [AW-1:0]      a_rd_addr, b_rd_addr;
    word_t [N-1:0]      a_rd_data, b_rd_data;
    logic               sa_start, sa_stall;
    word_t [N-1:0]      sa_x_in, sa_w_in, sa_y_out;
    logic [RW-1:0]      sa_y_index, out_idx;
    logic               out_valid, out_ready, out_last;
    word_t [N-1:0]      out_row;
    logic               done, err, busy;
    ctrl_state_t        dbg_state;

    systolic_controller #(.N(N), .KMAX(KMAX)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .sa_start(sa_start), .sa_x_in(sa_x_in), .sa_w_in(sa_w_in),
        .sa_y_index(sa_y_index), .sa_y_out(sa_y_out), .sa_stall(sa_stall),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_idx(out_idx), .out_last(out_last),
        .done(done), .err(err), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- environment: operand buffers + array ----------------
    word_t a_mat [N][KMAX];
    word_t b_mat [KMAX][N];
    word_t [N-1:0] a_mem [KMAX];
    word_t [N-1:0] b_mem [KMAX];

    word_t [N-1:0] acc [N];
    word_t xr [N][N];
    word_t wr [N][N];

    logic a_en_s, b_en_s, start_s, stall_s;
    logic [AW-1:0] a_addr_s, b_addr_s;
    word_t [N-1:0] x_s, w_s;

    initial begin
        a_rd_data = '0;
        b_rd_data = '0;
        for (int i = 0; i < N; i++) begin
            acc[i] = '0;
            for (int j = 0; j < N; j++) begin xr[i][j] = '0; wr[i][j] = '0; end
        end
    end

    always @(negedge clk) begin
        a_en_s = a_rd_en; a_addr_s = a_rd_addr;
        b_en_s = b_rd_en; b_addr_s = b_rd_addr;
        start_s = sa_start; stall_s = sa_stall;
        x_s = sa_x_in; w_s = sa_w_in;
    end

    always @(posedge clk) begin
        word_t xv, wv;
        if (a_en_s) a_rd_data <= a_mem[a_addr_s];
        if (b_en_s) b_rd_data <= b_mem[b_addr_s];
        if (!stall_s) begin
            for (int i = N - 1; i >= 0; i--) begin
                for (int j = N - 1; j >= 0; j--) begin
                    if (start_s) begin
                        acc[i][j] = '0; xr[i][j] = '0; wr[i][j] = '0;
                    end else begin
                        xv = (j == 0) ? x_s[i] : xr[i][j-1];
                        wv = (i == 0) ? w_s[j] : wr[i-1][j];
                        acc[i][j] = acc[i][j] + xv * wv;
                        xr[i][j] = xv;
                        wr[i][j] = wv;
                    end
                end
            end
        end
    end

    assign sa_y_out = acc[sa_y_index];

    // ---------------- scoreboard state ----------------
    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  got_rows [$];
    logic [RW-1:0] got_idx [$];
    logic          got_last [$];
    int n_vec = 0;
    int n_err = 0;

    // Fill operands for one tile and queue the expected rows Y = A*B.
    // mode 0: A=I, B[k][j]=4k+j; 1: A[i][k]=i+1, B=2; else random bytes.
    task automatic load_tile(input int k, input int mode);
        word_t s;
        logic [W-1:0] row;
        for (int kk = 0; kk < KMAX; kk++)
            for (int i = 0; i < N; i++) begin a_mat[i][kk] = '0; b_mat[kk][i] = '0; end
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0: begin a_mat[i][kk] = (i == kk) ? 16'd1 : 16'd0; b_mat[kk][i] = word_t'(4 * kk + i); end
                    1: begin a_mat[i][kk] = word_t'(i + 1); b_mat[kk][i] = 16'd2; end
                    default: begin
                        a_mat[i][kk] = word_t'($urandom_range(0, 255));
                        b_mat[kk][i] = word_t'($urandom_range(0, 255));
                    end
                endcase
            end
        end
        for (int kk = 0; kk < KMAX; kk++)
            for (int i = 0; i < N; i++) begin a_mem[kk][i] = a_mat[i][kk]; b_mem[kk][i] = b_mat[kk][i]; end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int kk = 0; kk < k; kk++) s = s + a_mat[i][kk] * b_mat[kk][j];
                row[j*16 +: 16] = s;
            end
            exp_q.push_back(row);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one command and follows the tile to done. Interval n=0 is the
    // cycle after the handshake edge. ready_mode 0: always ready,
    // 1: pattern 1,0,0,..., 2: random.
    task automatic run_tile(input int k, input int stall_at, input int stall_len,
                            input int ready_mode, output int first_v, output int done_n,
                            output bit rd_in_stall, output bit unstable);
        bit prev_blocked;
        word_t [N-1:0] prev_row;
        logic [RW-1:0] prev_idx;
        got_rows.delete(); got_idx.delete(); got_last.delete();
        first_v = -1; done_n = -1; rd_in_stall = 0; unstable = 0; prev_blocked = 0;
        prev_row = '0; prev_idx = '0;
        cmd_valid = 1'b1;
        cmd_k = KW'(k);
        sa_stall = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            sa_stall = (n >= stall_at) && (n < stall_at + stall_len);
            out_ready = (ready_mode == 0) ? 1'b1 :
                        (ready_mode == 1) ? (n % 3 == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (sa_stall && (a_rd_en || b_rd_en)) rd_in_stall = 1;
            if (out_valid && first_v < 0) first_v = n;
            if (prev_blocked && out_valid && (out_row !== prev_row || out_idx !== prev_idx)) unstable = 1;
            prev_blocked = out_valid && !out_ready;
            prev_row = out_row;
            prev_idx = out_idx;
            if (out_valid && out_ready) begin
                got_rows.push_back(out_row);
                got_idx.push_back(out_idx);
                got_last.push_back(out_last);
            end
            if (done) begin done_n = n; break; end
            @(posedge clk); #1;
        end
        sa_stall = 1'b0;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_k = '0; out_ready = 1'b0; sa_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== IDLE) begin
            n_err++; $display("FAIL reset_status: cmd_ready=%b busy=%b state=%0d expected 1 0 0", cmd_ready, busy, dbg_state);
        end
        n_vec++;
        if ({sa_start, a_rd_en, b_rd_en, out_valid, out_last, done, err} !== 7'b0 ||
            {a_rd_addr, b_rd_addr, sa_y_index, out_idx} !== '0) begin
            n_err++; $display("FAIL reset_ctrl: start/rd/out/done/err/addr/idx not all zero");
        end
        n_vec++;
        if (sa_x_in !== '0 || sa_w_in !== '0 || out_row !== '0) begin
            n_err++; $display("FAIL reset_data: x=%h w=%h row=%h expected 0", sa_x_in, sa_w_in, out_row);
        end
    endtask

    task automatic test_identity();
        int fv, dn; bit ris, uns; logic [W-1:0] e;
        load_tile(4, 0);
        run_tile(4, -1, 0, 0, fv, dn, ris, uns);
        n_vec++;
        if (fv !== 12 || dn !== 16) begin
            n_err++; $display("FAIL ident_timing: first_valid=%0d done=%0d expected 12 16", fv, dn);
        end
        n_vec++;
        if (got_rows.size() != N) begin
            n_err++; $display("FAIL ident_count: got %0d rows expected %0d", got_rows.size(), N);
        end
        for (int r = 0; r < N; r++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (r >= got_rows.size() || got_rows[r] !== e || got_idx[r] !== RW'(r) || got_last[r] !== (r == N - 1)) begin
                n_err++; $display("FAIL ident_row%0d: got %h expected %h (idx/last)", r, (r < got_rows.size()) ? got_rows[r] : '0, e);
            end
        end
    endtask

    task automatic test_k1();
        int fv, dn; bit ris, uns; logic [W-1:0] e;
        load_tile(1, 1);
        run_tile(1, -1, 0, 0, fv, dn, ris, uns);
        n_vec++;
        if (fv !== 9 || dn !== 13) begin
            n_err++; $display("FAIL k1_timing: first_valid=%0d done=%0d expected 9 13", fv, dn);
        end
        for (int r = 0; r < N; r++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (r >= got_rows.size() || got_rows[r] !== e) begin
                n_err++; $display("FAIL k1_row%0d: got %h expected %h", r, (r < got_rows.size()) ? got_rows[r] : '0, e);
            end
        end
    endtask

    task automatic test_stall();
        int fv, dn; bit ris, uns; logic [W-1:0] e;
        load_tile(4, 0);
        run_tile(4, 3, 3, 0, fv, dn, ris, uns);
        n_vec++;
        if (dn !== 19) begin
            n_err++; $display("FAIL stall_done: done at %0d expected 19", dn);
        end
        n_vec++;
        if (ris !== 1'b0) begin
            n_err++; $display("FAIL stall_rd_en: read enable seen during stall=%b expected 0", ris);
        end
        for (int r = 0; r < N; r++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (r >= got_rows.size() || got_rows[r] !== e) begin
                n_err++; $display("FAIL stall_row%0d: got %h expected %h", r, (r < got_rows.size()) ? got_rows[r] : '0, e);
            end
        end
    endtask

    task automatic test_backpressure();
        int fv, dn; bit ris, uns; logic [W-1:0] e;
        load_tile(4, 2);
        run_tile(4, -1, 0, 1, fv, dn, ris, uns);
        n_vec++;
        if (uns !== 1'b0 || got_rows.size() != N) begin
            n_err++; $display("FAIL bp_stable: unstable=%b rows=%0d expected 0 %0d", uns, got_rows.size(), N);
        end
        for (int r = 0; r < N; r++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (r >= got_rows.size() || got_rows[r] !== e || got_idx[r] !== RW'(r)) begin
                n_err++; $display("FAIL bp_row%0d: got %h expected %h", r, (r < got_rows.size()) ? got_rows[r] : '0, e);
            end
        end
    endtask

    task automatic test_reset_mid_feed();
        int fv, dn; bit ris, uns; bit saw_done; logic [W-1:0] e;
        load_tile(4, 0);
        exp_q.delete();
        cmd_valid = 1'b1; cmd_k = KW'(4);
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dbg_state !== IDLE || cmd_ready !== 1'b1 || busy !== 1'b0 || sa_start !== 1'b0 ||
            a_rd_en !== 1'b0 || b_rd_en !== 1'b0 || sa_x_in !== '0 || sa_w_in !== '0 ||
            out_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_err++; $display("FAIL midrst_idle: state=%0d busy=%b x=%h w=%h expected IDLE 0 0 0", dbg_state, busy, sa_x_in, sa_w_in);
        end
        saw_done = 0;
        repeat (20) begin @(negedge clk); if (done || busy) saw_done = 1; end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++; $display("FAIL midrst_quiet: done/busy after reset=%b expected 0", saw_done);
        end
        load_tile(4, 0);
        run_tile(4, -1, 0, 0, fv, dn, ris, uns);
        for (int r = 0; r < N; r++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (r >= got_rows.size() || got_rows[r] !== e) begin
                n_err++; $display("FAIL midrst_row%0d: got %h expected %h", r, (r < got_rows.size()) ? got_rows[r] : '0, e);
            end
        end
    endtask

    task automatic test_err_and_zero();
        int fv, dn; bit ris, uns; bit saw_start; logic [W-1:0] e;
        cmd_valid = 1'b1; cmd_k = KW'(KMAX + 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (err !== 1'b1 || done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL err_pulse: err=%b done=%b ready=%b busy=%b expected 1 1 1 0", err, done, cmd_ready, busy);
        end
        saw_start = sa_start;
        @(negedge clk);
        n_vec++;
        if (err !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL err_width: err=%b done=%b expected 0 0 one cycle later", err, done);
        end
        repeat (4) begin @(negedge clk); if (sa_start || a_rd_en) saw_start = 1; end
        n_vec++;
        if (saw_start !== 1'b0) begin
            n_err++; $display("FAIL err_noarray: array activity=%b expected 0", saw_start);
        end
        load_tile(0, 2);
        run_tile(0, -1, 0, 0, fv, dn, ris, uns);
        n_vec++;
        if (dn !== 3 * N) begin
            n_err++; $display("FAIL k0_done: done at %0d expected %0d", dn, 3 * N);
        end
        for (int r = 0; r < N; r++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (r >= got_rows.size() || got_rows[r] !== e) begin
                n_err++; $display("FAIL k0_row%0d: got %h expected %h", r, (r < got_rows.size()) ? got_rows[r] : '0, e);
            end
        end
    endtask

    task automatic test_random();
        int fv, dn, k, sat, sln, rm, exp_done; bit ris, uns; logic [W-1:0] e;
        for (int t = 0; t < 10; t++) begin
            k   = (t == 9) ? KMAX : int'($urandom_range(1, 12));
            sat = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, k + 2 * N + 2)) : -1;
            sln = (sat >= 0) ? int'($urandom_range(1, 3)) : 0;
            rm  = (t % 2 == 0) ? 0 : 2;
            load_tile(k, 2);
            run_tile(k, sat, sln, rm, fv, dn, ris, uns);
            // Stall cycles landing before READ stretch the tile one-for-one.
            exp_done = k + 3 * N + ((sat >= 0 && sat < k + 2 * N) ? sln : 0);
            if (rm == 0) begin
                n_vec++;
                if (dn !== exp_done) begin
                    n_err++; $display("FAIL rnd%0d_done: done at %0d expected %0d (K=%0d)", t, dn, exp_done, k);
                end
            end
            n_vec++;
            if (dn < 0 || got_rows.size() != N || ris !== 1'b0 || uns !== 1'b0) begin
                n_err++; $display("FAIL rnd%0d_flow: done=%0d rows=%0d rd_in_stall=%b unstable=%b", t, dn, got_rows.size(), ris, uns);
            end
            for (int r = 0; r < N; r++) begin
                e = exp_q.pop_front();
                n_vec++;
                if (r >= got_rows.size() || got_rows[r] !== e || got_idx[r] !== RW'(r)) begin
                    n_err++; $display("FAIL rnd%0d_row%0d: got %h expected %h", t, r, (r < got_rows.size()) ? got_rows[r] : '0, e);
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_identity();
        test_k1();
        test_stall();
        test_backpressure();
        test_reset_mid_feed();
        test_err_and_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
